// File: rtl/definitions.sv
// Shared types for the control sequencer: operation mnemonics, FSM states and opcode encodings.
package definitions;

    typedef enum logic [2:0] {
        LW,
        SW,
        SET,
        BNE,
        PAR,
        ADD,
        XOR,
        LSOR
    } op_mne;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } ctrl_state_t;

    localparam logic [2:0] OPC_MEM  = 3'b000;
    localparam logic [2:0] OPC_ILL  = 3'b001;
    localparam logic [2:0] OPC_SET  = 3'b010;
    localparam logic [2:0] OPC_BNE  = 3'b011;
    localparam logic [2:0] OPC_PAR  = 3'b100;
    localparam logic [2:0] OPC_ADD  = 3'b101;
    localparam logic [2:0] OPC_XOR  = 3'b110;
    localparam logic [2:0] OPC_LSOR = 3'b111;

endpackage

// File: rtl/op_decode.sv
// Combinational instruction decoder: opcode to mnemonic, plus illegal and halt flags.
module op_decode
    import definitions::*;
#(
    parameter int unsigned        INSTR_W    = 9,
    parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
    input  logic [INSTR_W-1:0] instr,
    output op_mne              op_c,
    output logic               illegal_c,
    output logic               halt_c
);

    logic [2:0] opcode;
    logic       sub;

    assign opcode = instr[INSTR_W-1 -: 3];
    assign sub    = instr[INSTR_W-4];
    assign halt_c = (instr == HALT_INSTR);

    always_comb begin
        op_c      = LW;
        illegal_c = 1'b0;
        case (opcode)
            OPC_MEM:  op_c = sub ? SW : LW;
            OPC_ILL:  illegal_c = 1'b1;
            OPC_SET:  op_c = SET;
            OPC_BNE:  op_c = BNE;
            OPC_PAR:  op_c = PAR;
            OPC_ADD:  op_c = ADD;
            OPC_XOR:  op_c = XOR;
            OPC_LSOR: op_c = LSOR;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb FSM with memory timeout and
// saturating cycle/retire counters. Every output is a flop.
module ctrl_sequencer
    import definitions::*;
#(
    parameter int unsigned        INSTR_W     = 9,
    parameter int unsigned        MEM_TIMEOUT = 16,
    parameter int unsigned        CNT_W       = 16,
    parameter logic [INSTR_W-1:0] HALT_INSTR  = '1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               mem_ack,
    output op_mne              alu_op,
    output logic               pc_en,
    output logic               branch_en,
    output logic               reg_we,
    output logic               mem_req,
    output logic               mem_we,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    op_mne            dec_op;
    logic             dec_illegal;
    logic             dec_halt;
    logic             illegal_q;
    logic             halt_q;
    logic [TMO_W-1:0] mem_cnt;
    logic             mem_expired;
    logic             cyc_active;

    logic pc_en_d;
    logic branch_en_d;
    logic reg_we_d;
    logic mem_req_d;
    logic mem_we_d;
    logic done_d;
    logic err_d;

    // The fetched word is kept in decoded form, so alu_op is already valid in DECODE.
    op_decode #(
        .INSTR_W    (INSTR_W),
        .HALT_INSTR (HALT_INSTR)
    ) u_op_decode (
        .instr     (instr),
        .op_c      (dec_op),
        .illegal_c (dec_illegal),
        .halt_c    (dec_halt)
    );

    assign mem_expired = (mem_cnt == TMO_W'(MEM_TIMEOUT));
    assign cyc_active  = !(state inside {IDLE, HALT, ERR});

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are computed for the state being entered and registered alongside it.
    always_comb begin
        state_next  = state;
        pc_en_d     = 1'b0;
        branch_en_d = 1'b0;
        reg_we_d    = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state)
            IDLE:   if (start) state_next = FETCH;
            FETCH:  if (instr_valid) state_next = DECODE;
            DECODE: begin
                if (halt_q)         state_next = HALT;
                else if (illegal_q) state_next = ERR;
                else                state_next = EXEC;
            end
            EXEC: begin
                case (alu_op)
                    LW, SW:  state_next = MEM;
                    BNE:     state_next = FETCH;
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (mem_ack) begin
                    state_next = (alu_op == SW) ? FETCH : WB;
                    pc_en_d    = (alu_op == SW);
                end else if (mem_expired) begin
                    state_next = ERR;
                end
            end
            WB:     state_next = FETCH;
            HALT:   if (start) state_next = FETCH;
            ERR:    state_next = ERR;
            default: state_next = IDLE;
        endcase

        mem_req_d   = (state_next == MEM);
        mem_we_d    = mem_req_d && (alu_op == SW);
        branch_en_d = (state == DECODE) && (state_next == EXEC) && (alu_op == BNE);
        reg_we_d    = (state_next == WB);
        pc_en_d     = pc_en_d || branch_en_d || reg_we_d;
        done_d      = (state_next == HALT);
        err_d       = (state_next == ERR);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_en      <= 1'b0;
            branch_en  <= 1'b0;
            reg_we     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            alu_op     <= LW;
            illegal_q  <= 1'b0;
            halt_q     <= 1'b0;
            mem_cnt    <= '0;
            cyc_cnt    <= '0;
            retire_cnt <= '0;
        end else begin
            pc_en     <= pc_en_d;
            branch_en <= branch_en_d;
            reg_we    <= reg_we_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            done      <= done_d;
            err       <= err_d;

            if (state == FETCH && instr_valid) begin
                alu_op    <= dec_op;
                illegal_q <= dec_illegal;
                halt_q    <= dec_halt;
            end

            // mem_cnt reads 1 in the first MEM cycle.
            if (state_next == MEM) begin
                mem_cnt <= (state == MEM) ? mem_cnt + TMO_W'(1) : TMO_W'(1);
            end else begin
                mem_cnt <= '0;
            end

            if (cyc_active && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (pc_en_d && retire_cnt != '1) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: per-cycle expected control vectors are queued as
// stimulus is driven and compared when the DUT answers; a narrow-counter copy covers saturation.
module tb_ctrl_sequencer;
    import definitions::*;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SAT_W   = 2;

    // Control vector bit positions: {pc_en, branch_en, reg_we, mem_req, mem_we, done, err}
    localparam logic [6:0] PC = 7'b1000000;
    localparam logic [6:0] BR = 7'b0100000;
    localparam logic [6:0] WE = 7'b0010000;
    localparam logic [6:0] MR = 7'b0001000;
    localparam logic [6:0] MW = 7'b0000100;
    localparam logic [6:0] DN = 7'b0000010;
    localparam logic [6:0] ER = 7'b0000001;

    localparam logic [8:0] I_ADD  = 9'b101_000011;
    localparam logic [8:0] I_LW   = 9'b000_0_00101;
    localparam logic [8:0] I_SW   = 9'b000_1_00101;
    localparam logic [8:0] I_BNE  = 9'b011_000010;
    localparam logic [8:0] I_ILL  = 9'b001_010101;
    localparam logic [8:0] I_HALT = 9'h1FF;
    localparam logic [8:0] I_LSOR = 9'b111_000001;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
    } exp_t;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               mem_ack;
    op_mne              alu_op;
    logic               pc_en, branch_en, reg_we, mem_req, mem_we, done, err;
    logic [CNT_W-1:0]   cyc_cnt, retire_cnt;

    op_mne              alu_op_s;
    logic               pc_en_s, branch_en_s, reg_we_s, mem_req_s, mem_we_s, done_s, err_s;
    logic [SAT_W-1:0]   cyc_cnt_s, retire_cnt_s;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 Clk = ~Clk;

    ctrl_sequencer #(
        .INSTR_W(INSTR_W), .MEM_TIMEOUT(16), .CNT_W(CNT_W), .HALT_INSTR(9'h1FF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .instr(instr), .instr_valid(instr_valid),
        .mem_ack(mem_ack), .alu_op(alu_op), .pc_en(pc_en), .branch_en(branch_en),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .done(done), .err(err),
        .cyc_cnt(cyc_cnt), .retire_cnt(retire_cnt)
    );

    ctrl_sequencer #(
        .INSTR_W(INSTR_W), .MEM_TIMEOUT(16), .CNT_W(SAT_W), .HALT_INSTR(9'h1FF)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .start(start), .instr(instr), .instr_valid(instr_valid),
        .mem_ack(mem_ack), .alu_op(alu_op_s), .pc_en(pc_en_s), .branch_en(branch_en_s),
        .reg_we(reg_we_s), .mem_req(mem_req_s), .mem_we(mem_we_s), .done(done_s), .err(err_s),
        .cyc_cnt(cyc_cnt_s), .retire_cnt(retire_cnt_s)
    );

    function automatic exp_t mk(input string tag, input logic [6:0] ctl);
        exp_t t;
        t.tag = tag;
        t.ctl = ctl;
        return t;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {pc_en, branch_en, reg_we, mem_req, mem_we, done, err};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic a, input logic [8:0] i);
        start       = s;
        instr_valid = v;
        mem_ack     = a;
        instr       = i;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0);
        step();
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0);
        step();
        n_checks++;
        if (ctl_now() !== 7'b0) begin
            n_errors++; $display("FAIL reset_ctl: got %b, expected %b", ctl_now(), 7'b0);
        end
        n_checks++;
        if (cyc_cnt !== CNT_W'(0) || retire_cnt !== CNT_W'(0)) begin
            n_errors++; $display("FAIL reset_cnt: got cyc=%0d ret=%0d, expected 0 0", cyc_cnt, retire_cnt);
        end
        n_checks++;
        if (alu_op !== LW) begin
            n_errors++; $display("FAIL reset_alu_op: got %0d, expected %0d", alu_op, LW);
        end
        Reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, I_ADD);
        step();
        step();
        n_checks++;
        if (ctl_now() !== 7'b0 || cyc_cnt !== CNT_W'(0)) begin
            n_errors++; $display("FAIL idle_no_start: got ctl=%b cyc=%0d, expected 0000000 0", ctl_now(), cyc_cnt);
        end
    endtask

    task automatic test_alu();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive(c == 1, c <= 2, 1'b0, I_ADD);
            exp_q.push_back(mk($sformatf("add_c%0d", c), (c == 4) ? (PC | WE) : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
            if (c == 4) begin
                n_checks++;
                if (retire_cnt !== CNT_W'(1) || cyc_cnt !== CNT_W'(3) || alu_op !== ADD) begin
                    n_errors++;
                    $display("FAIL add_wb_state: got ret=%0d cyc=%0d op=%0d, expected 1 3 %0d",
                             retire_cnt, cyc_cnt, alu_op, ADD);
                end
            end
        end
    endtask

    task automatic test_bne();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(c == 1, c <= 2, 1'b0, I_BNE);
            exp_q.push_back(mk($sformatf("bne_c%0d", c), (c == 3) ? (PC | BR) : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
            if (c == 3) begin
                n_checks++;
                if (retire_cnt !== CNT_W'(1) || alu_op !== BNE) begin
                    n_errors++; $display("FAIL bne_exec: got ret=%0d op=%0d, expected 1 %0d", retire_cnt, alu_op, BNE);
                end
            end
        end
    endtask

    task automatic test_lw();
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            drive(c == 1, c <= 2, c == 8, I_LW);
            exp_q.push_back(mk($sformatf("lw_c%0d", c),
                               (c >= 4 && c <= 7) ? MR : (c == 8) ? (PC | WE) : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        n_checks++;
        if (retire_cnt !== CNT_W'(1) || cyc_cnt !== CNT_W'(8) || alu_op !== LW) begin
            n_errors++; $display("FAIL lw_done: got ret=%0d cyc=%0d op=%0d, expected 1 8 %0d", retire_cnt, cyc_cnt, alu_op, LW);
        end
    endtask

    task automatic test_sw_ack();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            drive(c == 1, c <= 2, c == 5, I_SW);
            exp_q.push_back(mk($sformatf("sw_c%0d", c), (c == 4) ? (MR | MW) : (c == 5) ? PC : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        n_checks++;
        if (retire_cnt !== CNT_W'(1) || alu_op !== SW) begin
            n_errors++; $display("FAIL sw_retire: got ret=%0d op=%0d, expected 1 %0d", retire_cnt, alu_op, SW);
        end
    endtask

    task automatic test_ack_priority();
        do_reset();
        for (int c = 1; c <= 21; c++) begin
            drive(c == 1, c <= 2, c == 20, I_SW);
            exp_q.push_back(mk($sformatf("prio_c%0d", c),
                               (c >= 4 && c <= 19) ? (MR | MW) : (c == 20) ? PC : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            drive(c == 1 || c >= 21, c <= 2, 1'b0, I_SW);
            exp_q.push_back(mk($sformatf("tmo_c%0d", c),
                               (c >= 4 && c <= 19) ? (MR | MW) : (c >= 20) ? ER : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        n_checks++;
        if (cyc_cnt !== CNT_W'(19) || retire_cnt !== CNT_W'(0)) begin
            n_errors++; $display("FAIL tmo_cnt: got cyc=%0d ret=%0d, expected 19 0", cyc_cnt, retire_cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            drive(c == 1 || c >= 4, c <= 2, 1'b0, I_ILL);
            exp_q.push_back(mk($sformatf("ill_c%0d", c), (c >= 3) ? ER : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        n_checks++;
        if (cyc_cnt !== CNT_W'(2)) begin
            n_errors++; $display("FAIL ill_cyc: got %0d, expected 2", cyc_cnt);
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (ctl_now() !== 7'b0 || cyc_cnt !== CNT_W'(0) || retire_cnt !== CNT_W'(0) || alu_op !== LW) begin
            n_errors++; $display("FAIL ill_async_reset: got ctl=%b cyc=%0d ret=%0d op=%0d, expected 0000000 0 0 %0d",
                                 ctl_now(), cyc_cnt, retire_cnt, alu_op, LW);
        end
        step();
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 9'd0);
        step();
        n_checks++;
        if (ctl_now() !== 7'b0) begin
            n_errors++; $display("FAIL ill_idle_after_reset: got %b, expected 0000000", ctl_now());
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            drive(c == 1 || c == 7, c <= 2, 1'b0, I_HALT);
            exp_q.push_back(mk($sformatf("halt_c%0d", c), (c >= 3 && c <= 6) ? DN : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
            if (c == 3 || c == 6 || c == 8) begin
                n_checks++;
                if (cyc_cnt !== ((c == 8) ? CNT_W'(3) : CNT_W'(2))) begin
                    n_errors++; $display("FAIL halt_cyc_c%0d: got %0d, expected %0d", c, cyc_cnt, (c == 8) ? 3 : 2);
                end
            end
        end
    endtask

    task automatic test_mem_reset();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive(c == 1, c <= 2, 1'b0, I_LW);
            exp_q.push_back(mk($sformatf("mrst_c%0d", c), (c >= 4) ? MR : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || ctl_now() !== 7'b0) begin
            n_errors++; $display("FAIL mrst_async: got mem_req=%b ctl=%b, expected 0 0000000", mem_req, ctl_now());
        end
        step();
        Reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            drive(c == 2, 1'b0, 1'b1, I_LW);
            exp_q.push_back(mk($sformatf("mrst_after_c%0d", c), 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
        end
        n_checks++;
        if (cyc_cnt !== CNT_W'(1)) begin
            n_errors++; $display("FAIL mrst_cyc: got %0d, expected 1", cyc_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            drive(c == 1, 1'b1, 1'b0, I_LSOR);
            exp_q.push_back(mk($sformatf("b2b_c%0d", c), (c % 4 == 0) ? (PC | WE) : 7'b0));
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl_now() !== e.ctl) begin
                n_errors++; $display("FAIL %s: ctl got %b, expected %b", e.tag, ctl_now(), e.ctl);
            end
            if (c == 8) begin
                n_checks++;
                if (retire_cnt_s !== SAT_W'(2)) begin
                    n_errors++; $display("FAIL sat_ret_pre: got %0d, expected 2", retire_cnt_s);
                end
            end
        end
        n_checks++;
        if (retire_cnt !== CNT_W'(4) || cyc_cnt !== CNT_W'(15) || alu_op !== LSOR) begin
            n_errors++; $display("FAIL b2b_cnt: got ret=%0d cyc=%0d op=%0d, expected 4 15 %0d", retire_cnt, cyc_cnt, alu_op, LSOR);
        end
        n_checks++;
        if (retire_cnt_s !== SAT_W'(3) || cyc_cnt_s !== SAT_W'(3)) begin
            n_errors++; $display("FAIL sat_cnt: got ret=%0d cyc=%0d, expected 3 3", retire_cnt_s, cyc_cnt_s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0);
        test_reset();
        test_alu();
        test_bne();
        test_lw();
        test_sw_ack();
        test_ack_priority();
        test_timeout();
        test_illegal();
        test_halt();
        test_mem_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 9: instruction width, at least 4; opcode is bits [INSTR_W-1:INSTR_W-3].
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: maximum MEM-state cycles to wait for mem_ack.
REQ-003 SHALL have parameter CNT_W, default 16: width of the cycle and retire counters.
REQ-004 SHALL have parameter HALT_INSTR, default all-ones of INSTR_W: the halt encoding.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin or resume execution.
REQ-008 SHALL have port instr, input, INSTR_W bits: fetched instruction.
REQ-009 SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-010 SHALL have port mem_ack, input, 1 bit: data memory completed the request.
REQ-011 SHALL have port alu_op, output, op_mne: decoded operation.
REQ-012 SHALL have outputs pc_en, branch_en, reg_we, mem_req, mem_we, done and err, each 1 bit.
REQ-013 SHALL have outputs cyc_cnt and retire_cnt, each CNT_W bits.

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT and ERR.
REQ-015 IDLE SHALL go to FETCH when start=1; start SHALL be ignored in every state except IDLE and HALT.
REQ-016 FETCH SHALL latch instr and go to DECODE when instr_valid=1, and SHALL otherwise hold.
REQ-017 DECODE SHALL decode the latched instruction in one cycle and go to:
- HALT if the instruction equals HALT_INSTR.
- ERR if the opcode is 3'b001 (illegal).
- EXEC otherwise.
REQ-018 Opcode 000 SHALL decode as LW when bit INSTR_W-4 is 0 and as SW when it is 1; the other opcodes SHALL map as SET=010, BNE=011, PAR=100, ADD=101, XOR=110, LSOR=111.
REQ-019 EXEC SHALL go to MEM for LW or SW.
REQ-020 EXEC SHALL pulse pc_en and branch_en together for one cycle for BNE, then go to FETCH.
REQ-021 EXEC SHALL go to WB for SET, PAR, ADD, XOR and LSOR.
REQ-022 MEM SHALL assert mem_req, with mem_we=1 only for SW, and hold both until mem_ack is seen.
REQ-023 On mem_ack, MEM SHALL go to WB for LW.
REQ-024 On mem_ack, MEM SHALL pulse pc_en and go to FETCH for SW.
REQ-025 MEM SHALL count its cycles starting at 1; if the count reaches MEM_TIMEOUT with no mem_ack, it SHALL go to ERR.
REQ-026 A mem_ack in the timeout cycle SHALL take priority over the timeout.
REQ-027 WB SHALL assert reg_we and pc_en for exactly one cycle, then go to FETCH.
REQ-028 HALT SHALL hold done=1 and go to FETCH on start, with done clearing as it leaves.
REQ-029 ERR SHALL hold err=1 and SHALL be left only by Reset.
REQ-030 alu_op SHALL be valid from DECODE through the retiring cycle and SHALL hold its last value otherwise.
REQ-031 cyc_cnt SHALL increment every cycle outside IDLE, HALT and ERR, and SHALL saturate at all-ones.
REQ-032 retire_cnt SHALL increment on each pc_en pulse and SHALL saturate at all-ones.
REQ-033 Minimum latencies from entering FETCH SHALL be:
- 4 cycles for ALU-type instructions.
- 3 cycles for BNE.
- 4 cycles plus ack delay for SW.
- 5 cycles plus ack delay for LW.

Reset
REQ-034 Reset SHALL force IDLE and clear all outputs, counters and the latched instruction immediately.
REQ-035 alu_op SHALL reset to LW.
REQ-036 Reset asserted during MEM SHALL drop mem_req asynchronously, with no pending request remembered.

Structure
REQ-037 The ctrl_state_t enum and the opcode constants SHALL be added to package definitions.
REQ-038 The existing op_mne enum in package definitions SHALL be reused for alu_op.
REQ-039 Decoding SHALL be a combinational sub-module named op_decode, which maps instr to op_mne plus an illegal flag.
REQ-040 All outputs SHALL be driven from the registered state and latched instruction only, with no combinational path from instr.

Verification
REQ-041 Reset, start=1, then ADD 9'b101_000011 with instr_valid=1 -> states FETCH, DECODE, EXEC, WB; reg_we and pc_en high in cycle 4; retire_cnt=1.
REQ-042 LW 9'b000_0_00101, with mem_ack held low for 3 MEM cycles -> mem_req high for 4 cycles with mem_we=0, then WB with reg_we=1; retire_cnt increments by 1.
REQ-043 SW 9'b000_1_00101 with MEM_TIMEOUT=16 and mem_ack never asserted -> mem_req and mem_we high for 16 cycles, then err=1, then stays in ERR.
REQ-044 Opcode 001 instruction -> ERR after DECODE, err=1; start is ignored; Reset returns to IDLE with all counters 0.
REQ-045 HALT_INSTR 9'h1FF -> done=1 and cyc_cnt frozen; start=1 -> FETCH and done=0.
REQ-046 Reset asserted mid-MEM in the 2nd MEM cycle -> mem_req=0 in the same cycle, state IDLE.
